// File: rtl/apb_fsm_controller.sv
// APB SETUP/ENABLE sequencer behind the AHB slave interface of the AHB-to-APB bridge.
// Optional APB_PREADY_EN: ENABLE phases wait for pready and stall the AHB master meanwhile.
module apb_fsm_controller #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NSEL   = 3
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              valid,
  input  logic              hwrite,
  input  logic              hwrite_reg,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [ADDR_W-1:0] haddr1,
  input  logic [ADDR_W-1:0] haddr2,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hwdata1,
  input  logic              pready,
  output logic              pwrite,
  output logic              penable,
  output logic [NSEL-1:0]   pselx,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hreadyout
);

  localparam int unsigned REGION_LSB = 26;
  localparam logic [ADDR_W-1:0] MAP_BASE = ADDR_W'(32'h8000_0000);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_READ,
    ST_WRITE,
    ST_WRITEP,
    ST_RENABLE,
    ST_WENABLE,
    ST_WENABLEP
  } state_t;

  state_t state;
  state_t state_nxt;

  // 64 MB windows starting at MAP_BASE map onto successive select lines
  function automatic logic [NSEL-1:0] sel_decode(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] offs;
    sel_decode = '0;
    offs = a - MAP_BASE;
    for (int unsigned i = 0; i < NSEL; i++) begin
      if ((offs >> REGION_LSB) == ADDR_W'(i)) sel_decode[i] = 1'b1;
    end
  endfunction

`ifdef APB_PREADY_EN
  logic enable_phase;
  assign enable_phase = (state == ST_RENABLE) || (state == ST_WENABLE) ||
                        (state == ST_WENABLEP);
`else
  logic pready_unused;
  assign pready_unused = pready;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_RENABLE, ST_WENABLE:
        state_nxt = valid ? (hwrite ? ST_WWAIT : ST_READ) : ST_IDLE;
      ST_WWAIT:    state_nxt = valid ? ST_WRITEP : ST_WRITE;
      ST_READ:     state_nxt = ST_RENABLE;
      ST_WRITE:    state_nxt = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP:   state_nxt = ST_WENABLEP;
      ST_WENABLEP: state_nxt = !hwrite_reg ? ST_READ : (valid ? ST_WRITEP : ST_WRITE);
      default:     state_nxt = ST_IDLE;
    endcase
`ifdef APB_PREADY_EN
    if (enable_phase && !pready) state_nxt = state;
`endif
  end

  // State and APB outputs, loaded with the values belonging to the state being entered
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= ST_IDLE;
      pwrite    <= 1'b0;
      penable   <= 1'b0;
      pselx     <= '0;
      paddr     <= '0;
      pwdata    <= '0;
      hreadyout <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state_nxt)
        ST_IDLE, ST_WWAIT: begin
          pselx     <= '0;
          penable   <= 1'b0;
          hreadyout <= 1'b1;
        end
        ST_READ: begin
          paddr     <= haddr;
          pwrite    <= 1'b0;
          pselx     <= sel_decode(haddr);
          penable   <= 1'b0;
          hreadyout <= 1'b0;
        end
        ST_WRITE, ST_WRITEP: begin
          // a write launched from WENABLEP had its address phase one cycle earlier
          if (state == ST_WENABLEP) begin
            paddr  <= haddr2;
            pwdata <= hwdata1;
            pselx  <= sel_decode(haddr2);
          end else begin
            paddr  <= haddr1;
            pwdata <= hwdata;
            pselx  <= sel_decode(haddr1);
          end
          pwrite    <= 1'b1;
          penable   <= 1'b0;
          hreadyout <= 1'b0;
        end
        default: begin
          penable <= 1'b1;
`ifdef APB_PREADY_EN
          hreadyout <= 1'b0;
`else
          hreadyout <= 1'b1;
`endif
        end
      endcase
`ifdef APB_PREADY_EN
      if (enable_phase && pready) hreadyout <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Self-checking bench for apb_fsm_controller: directed scenarios then random traffic
// compared each cycle against a phase-level reference model.
module tb_apb_fsm_controller;

  logic        hclk = 1'b0;
  logic        hreset, valid, hwrite, hwrite_reg, pready;
  logic [31:0] haddr, haddr1, haddr2, hwdata, hwdata1;
  logic        pwrite, penable, hreadyout;
  logic [2:0]  pselx;
  logic [31:0] paddr, pwdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 hclk = ~hclk;

  apb_fsm_controller dut (
    .hclk(hclk), .hreset(hreset), .valid(valid), .hwrite(hwrite), .hwrite_reg(hwrite_reg),
    .haddr(haddr), .haddr1(haddr1), .haddr2(haddr2), .hwdata(hwdata), .hwdata1(hwdata1),
    .pready(pready), .pwrite(pwrite), .penable(penable), .pselx(pselx), .paddr(paddr),
    .pwdata(pwdata), .hreadyout(hreadyout)
  );

  // Reference: APB phase plus transfer attributes; expected bus values kept alongside
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_SETUP = 2, PH_ACCESS = 3;
  int          ph;
  bit          m_wr, m_pipe;
  logic [31:0] e_paddr, e_pwdata;
  logic        e_pwrite, e_pen, e_hrdy;
  logic [2:0]  e_psel;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_sel(input logic [31:0] a);
    ref_sel = 3'b000;
    if (a >= 32'h8000_0000 && a <= 32'h8BFF_FFFF)
      ref_sel = 3'b001 << ((a - 32'h8000_0000) / 32'h0400_0000);
  endfunction

  task automatic go_quiet(input int next_ph);
    ph = next_ph; e_psel = 3'b000; e_pen = 1'b0; e_hrdy = 1'b1;
  endtask

  task automatic launch_read(input logic [31:0] a);
    ph = PH_SETUP; m_wr = 1'b0; m_pipe = 1'b0;
    e_paddr = a; e_pwrite = 1'b0; e_psel = ref_sel(a); e_pen = 1'b0; e_hrdy = 1'b0;
  endtask

  task automatic launch_write(input logic [31:0] a, input logic [31:0] d, input bit pipe);
    ph = PH_SETUP; m_wr = 1'b1; m_pipe = pipe;
    e_paddr = a; e_pwdata = d; e_pwrite = 1'b1; e_psel = ref_sel(a); e_pen = 1'b0; e_hrdy = 1'b0;
  endtask

  task automatic accept_new();
    if (valid && hwrite) go_quiet(PH_WAIT);
    else if (valid)      launch_read(haddr);
    else                 go_quiet(PH_IDLE);
  endtask

  task automatic model_step();
    bit leaving;
    if (hreset) begin
      ph = PH_IDLE; m_wr = 1'b0; m_pipe = 1'b0;
      e_paddr = '0; e_pwdata = '0; e_pwrite = 1'b0; e_pen = 1'b0; e_psel = 3'b000; e_hrdy = 1'b1;
      return;
    end
    leaving = (ph == PH_ACCESS);
`ifdef APB_PREADY_EN
    if (leaving && !pready) begin
      e_hrdy = 1'b0;
      return;
    end
`endif
    case (ph)
      PH_IDLE: accept_new();
      PH_WAIT: launch_write(haddr1, hwdata, valid);
      PH_SETUP: begin
        ph = PH_ACCESS;
        m_pipe = m_pipe | (m_wr & valid);
        e_pen = 1'b1;
`ifdef APB_PREADY_EN
        e_hrdy = 1'b0;
`else
        e_hrdy = 1'b1;
`endif
      end
      default: begin
        if (m_wr && m_pipe) begin
          if (!hwrite_reg) launch_read(haddr);
          else             launch_write(haddr2, hwdata1, valid);
        end else begin
          accept_new();
        end
      end
    endcase
`ifdef APB_PREADY_EN
    if (leaving) e_hrdy = 1'b1;
`endif
  endtask

  // One bus cycle: shift the upstream delay copies, drive live inputs at negedge,
  // advance the model after the edge, compare at the next negedge
  task automatic cycle(input logic rst, input logic v, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic rdy);
    hwrite_reg = hwrite; haddr2 = haddr1; haddr1 = haddr; hwdata1 = hwdata;
    hreset = rst; valid = v; hwrite = w; haddr = a; hwdata = d; pready = rdy;
    @(posedge hclk);
    #1;
    model_step();
    @(negedge hclk);
    check("paddr",     64'(paddr),     64'(e_paddr));
    check("pwdata",    64'(pwdata),    64'(e_pwdata));
    check("pwrite",    64'(pwrite),    64'(e_pwrite));
    check("penable",   64'(penable),   64'(e_pen));
    check("pselx",     64'(pselx),     64'(e_psel));
    check("hreadyout", 64'(hreadyout), 64'(e_hrdy));
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] edges [8];
    int k;
    edges = '{32'h8000_0000, 32'h83FF_FFFF, 32'h8400_0000, 32'h87FF_FFFC,
              32'h8800_0000, 32'h8BFF_FFFF, 32'h8C00_0000, 32'h7FFF_FFFF};
    k = int'($urandom_range(0, 11));
    if (k < 8)       pick_addr = edges[k];
    else if (k < 11) pick_addr = 32'h8000_0000 + $urandom_range(0, 32'h0BFF_FFFF);
    else             pick_addr = $urandom;
  endfunction

  initial begin
    hreset = 1'b1; valid = 1'b0; hwrite = 1'b0; hwrite_reg = 1'b0; pready = 1'b1;
    haddr = '0; haddr1 = '0; haddr2 = '0; hwdata = '0; hwdata1 = '0;
    ph = PH_IDLE; m_wr = 1'b0; m_pipe = 1'b0;
    e_paddr = '0; e_pwdata = '0; e_pwrite = 1'b0; e_pen = 1'b0; e_psel = 3'b000; e_hrdy = 1'b1;
    @(negedge hclk);

    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("rst_hready", 64'(hreadyout), 64'(1));
    check("rst_psel",   64'(pselx),     64'(0));

    // single read
    cycle(1'b0, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 1'b1);
    check("rd_psel",  64'(pselx),     64'(3'b001));
    check("rd_paddr", 64'(paddr),     64'(32'h8000_0010));
    check("rd_hrdy",  64'(hreadyout), 64'(0));
    idle_cycle();
    check("rd_pen",   64'(penable),   64'(1));
`ifndef APB_PREADY_EN
    check("rd_hrdy_en", 64'(hreadyout), 64'(1));
`endif
    idle_cycle();
`ifndef APB_PREADY_EN
    check("rd_done_psel", 64'(pselx), 64'(0));
`endif

    // reset held two cycles while in RENABLE
    repeat (2) idle_cycle();
    cycle(1'b0, 1'b1, 1'b0, 32'h8400_0100, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("mid_rst_paddr", 64'(paddr),     64'(0));
    check("mid_rst_pen",   64'(penable),   64'(0));
    check("mid_rst_hrdy",  64'(hreadyout), 64'(1));

    // single write
    cycle(1'b0, 1'b1, 1'b1, 32'h8400_0020, 32'h0, 1'b1);
    check("wr_wait_hrdy", 64'(hreadyout), 64'(1));
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1);
    check("wr_psel",   64'(pselx),  64'(3'b010));
    check("wr_paddr",  64'(paddr),  64'(32'h8400_0020));
    check("wr_pwdata", 64'(pwdata), 64'(32'hDEAD_BEEF));
    check("wr_pwrite", 64'(pwrite), 64'(1));
    idle_cycle();
    check("wr_pen", 64'(penable), 64'(1));
    repeat (2) idle_cycle();

    // back-to-back writes
    cycle(1'b0, 1'b1, 1'b1, 32'h8800_0000, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 32'h8800_0004, 32'h11, 1'b1);
    check("b2b_a0", 64'(paddr),  64'(32'h8800_0000));
    check("b2b_d0", 64'(pwdata), 64'(32'h11));
    cycle(1'b0, 1'b0, 1'b1, 32'h8800_0004, 32'h22, 1'b1);
    check("b2b_pen0", 64'(penable), 64'(1));
    check("b2b_sel0", 64'(pselx),   64'(3'b100));
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("b2b_a1",   64'(paddr),  64'(32'h8800_0004));
    check("b2b_d1",   64'(pwdata), 64'(32'h22));
    check("b2b_sel1", 64'(pselx),  64'(3'b100));
    idle_cycle();
    check("b2b_pen1", 64'(penable), 64'(1));
    repeat (2) idle_cycle();

    // write followed by read
    cycle(1'b0, 1'b1, 1'b1, 32'h8400_0000, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h8000_0100, 32'h55, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h8000_0100, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h8000_0100, 32'h0, 1'b1);
    check("wr_rd_paddr",  64'(paddr),  64'(32'h8000_0100));
    check("wr_rd_pwrite", 64'(pwrite), 64'(0));
    check("wr_rd_psel",   64'(pselx),  64'(3'b001));
    repeat (2) idle_cycle();

    // out-of-map read still sequences
    cycle(1'b0, 1'b1, 1'b0, 32'h9000_0000, 32'h0, 1'b1);
    check("oom_psel", 64'(pselx),     64'(0));
    check("oom_hrdy", 64'(hreadyout), 64'(0));
    repeat (2) idle_cycle();

`ifdef APB_PREADY_EN
    cycle(1'b0, 1'b1, 1'b0, 32'h8000_0040, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("wait_pen",  64'(penable),   64'(1));
      check("wait_hrdy", 64'(hreadyout), 64'(0));
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, (i == 2) ? 1'b1 : 1'b0);
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("wait_exit_hrdy", 64'(hreadyout), 64'(1));
    check("wait_exit_pen",  64'(penable),   64'(0));
    repeat (2) idle_cycle();
`endif

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            pick_addr(),
            $urandom,
            ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
